uart_rx: RTL and testbench
==========================

# uart_rx

UART receive engine for the FPGA debug link: deserializes the `rxd` line into bytes and presents them through a one-entry holding register with a valid/ack handshake. It is the receiving end of the serial link whose transmit side drives `TxD`. Host commands enter the board through it, and the trace wrapper consumes its output. Frame format is fixed 8N1, LSB first, with 16x oversampling.

## Interface
- `BAUD_DIV`, 163: clocks per oversample tick (25 MHz / (9600 × 16), rounded); legal range ≥ 2
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `rxd`  in  1  serial line, asynchronous to `clk`, idles high
- `rx_data`  out  8  received byte; valid while `rx_valid` = 1
- `rx_valid`  out  1  level; holding register full
- `rx_ack`  in  1  consumer pops the holding register (single-cycle)
- `rx_frame_err`  out  1  one-cycle pulse; stop bit sampled low
- `rx_overrun`  out  1  one-cycle pulse; unacked byte overwritten
- `rx_busy`  out  1  high in every state except IDLE

## Operation
- Clock and reset are fixed as follows: one clock `clk`; `reset` is asynchronous and active-low.
- **Reset values:** `rx_data` = 0x00; `rx_valid`, `rx_frame_err`, `rx_overrun`, `rx_busy` = 0; synchronizer flops = 1; `armed` = 0; state = IDLE; counters = 0.
- **Synchronizer:** a 2-FF synchronizer on `rxd`. All logic uses only the synchronized value `rxs`.
- **Arming:** `armed` sets on the first clock with `rxs` = 1 after reset. It clears on a frame error and re-sets when `rxs` = 1 again. A line held low through reset or a break therefore never starts a frame.
- **Tick counter:** counts 0..BAUD_DIV-1 and asserts `tick` when the count is BAUD_DIV-1. It is cleared on start detection.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: if `armed` and `rxs` = 0, go to START and clear the tick counter and sample counter.
  - START: at the 8th tick (mid-start-bit), go to DATA if `rxs` = 0; otherwise treat it as a false start and return to IDLE with no flags.
  - DATA: every 16th tick, shift `rxs` into bit[7] of the shift register (right shift, LSB first). After the 8th bit, go to STOP.
  - STOP: at the 16th tick (mid-stop-bit):
    - If `rxs` = 1, load the holding register.
    - Otherwise pulse `rx_frame_err`, discard the byte and clear `armed`.
    - In both cases return to IDLE. The FSM does not wait for the end of the stop bit.
- **Holding register:**
  - On a load, `rx_data` ← the shift register and `rx_valid` ← 1.
  - If `rx_valid` was already 1 and `rx_ack` is 0 in the same cycle, pulse `rx_overrun`; the new byte replaces the old one.
  - Load and `rx_ack` in the same cycle: the load wins, `rx_valid` stays 1, and there is no overrun.
  - `rx_ack` with no load: `rx_valid` ← 0 and `rx_data` holds its value.
  - `rx_ack` while `rx_valid` = 0 is ignored.
- **Reset mid-frame:** the partial byte is lost and nothing is reported. The holding register and flags clear immediately (asynchronously).

## Timing
- Define cycle 0 as the clock at which `rxd` first samples low. `rxs` is low from cycle 2, which is also when start detection and counter clear occur.
- The mid-start sample is at cycle 2 + 8·BAUD_DIV.
- Data bit k (k = 0..7) is sampled at cycle 2 + (24 + 16k)·BAUD_DIV.
- The stop bit is sampled at cycle 2 + 152·BAUD_DIV.
- `rx_valid` / `rx_frame_err` are visible from cycle 3 + 152·BAUD_DIV.
- Flag pulses last exactly one cycle. `rx_valid` clears on the edge after `rx_ack`.
- Back-to-back frames are accepted. A start edge occurring 8 ticks after the stop sample (a nominal stop-bit end) is detected.

## Structure
- **Package `uart_pkg`:**
  - state enum `uart_state_t` {IDLE, START, DATA, STOP}
  - `OVERSAMPLE` = 16, `DATA_BITS` = 8, `MID_SAMPLE` = 8
  - these constants are shared with the transmitter
- **Sub-module `uart_baud_tick`:** parameter `BAUD_DIV`; inputs `clk`, `reset`, `clear`; output `tick`. It is reused by the transmitter.
- The synchronizer, FSM and holding register stay inline.

## Test plan
All tests use BAUD_DIV = 4 (one bit = 64 clocks).
1. Send 0xA5 as a correct 8N1 frame → `rx_valid` = 1 at cycle 611 after the falling edge, `rx_data` = 0xA5, held until `rx_ack`; cleared the next cycle.
2. Drive `rxd` low for 16 clocks then high → `rx_busy` pulses, no `rx_valid`, no `rx_frame_err`; state back in IDLE by cycle 35.
3. Send 0x3C with the stop bit = 0 → a single `rx_frame_err` pulse at cycle 611 and `rx_valid` stays 0. Hold the line low for a further 200 clocks: no new frame starts. Raise the line, then send 0x7E → 0x7E is received.
4. Send 0x11 then 0x22 back-to-back with no ack → one `rx_overrun` pulse, `rx_data` = 0x22, `rx_valid` = 1. Repeat with `rx_ack` asserted in the load cycle → no overrun, `rx_valid` stays 1.
5. Assert `reset` 300 clocks into a 0x5A frame, release with the line high, then send 0x81 → only 0x81 appears. All outputs read 0 during reset.
6. Hold `rxd` low across reset release for 100 clocks, then raise it and send 0xC3 → no activity before the line goes high; 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame/oversampling constants
// used by both the receive and transmit engines.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int MID_SAMPLE = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: pulses tick once every BAUD_DIV clocks and
// restarts its count on clear so the phase can be aligned to a start edge.
module uart_baud_tick #(
    parameter int BAUD_DIV = 163
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(BAUD_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, break/low-line arming guard and a
// one-entry holding register with valid/ack handshake.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 163
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    logic                 sync1;
    logic                 rxs;
    logic [1:0]           primed;
    logic                 armed;
    uart_state_t          state;
    uart_state_t          state_next;
    logic [SW-1:0]        sample_cnt;
    logic [SW-1:0]        sample_next;
    logic [BW-1:0]        bit_cnt;
    logic [BW-1:0]        bit_next;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_next;
    logic                 tick;
    logic                 clear;
    logic                 load;
    logic                 ferr;

    uart_baud_tick #(
        .BAUD_DIV(BAUD_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clear(clear),
        .tick (tick)
    );

    // primed keeps the synchronizer's reset value of 1 from arming the
    // receiver before the real line level has propagated through both flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= 1'b1;
            rxs    <= 1'b1;
            primed <= 2'b00;
            armed  <= 1'b0;
        end else begin
            sync1  <= rxd;
            rxs    <= sync1;
            primed <= {primed[0], 1'b1};
            if (ferr) begin
                armed <= 1'b0;
            end else if (rxs && primed[1]) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
        end else begin
            state      <= state_next;
            sample_cnt <= sample_next;
            bit_cnt    <= bit_next;
        end
    end

    always_ff @(posedge clk) begin
        shift <= shift_next;
    end

    always_comb begin
        state_next  = state;
        sample_next = sample_cnt;
        bit_next    = bit_cnt;
        shift_next  = shift;
        clear       = 1'b0;
        load        = 1'b0;
        ferr        = 1'b0;
        case (state)
            IDLE: begin
                if (armed && !rxs) begin
                    state_next  = START;
                    clear       = 1'b1;
                    sample_next = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (sample_cnt == SW'(MID_SAMPLE - 1)) begin
                        sample_next = '0;
                        bit_next    = '0;
                        state_next  = rxs ? IDLE : DATA;
                    end else begin
                        sample_next = sample_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (sample_cnt == SW'(OVERSAMPLE - 1)) begin
                        sample_next = '0;
                        shift_next  = {rxs, shift[DATA_BITS-1:1]};
                        bit_next    = bit_cnt + 1'b1;
                        if (bit_cnt == BW'(DATA_BITS - 1)) begin
                            state_next = STOP;
                        end
                    end else begin
                        sample_next = sample_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (sample_cnt == SW'(OVERSAMPLE - 1)) begin
                        sample_next = '0;
                        state_next  = IDLE;
                        load        = rxs;
                        ferr        = !rxs;
                    end else begin
                        sample_next = sample_cnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A load always wins over a same-cycle ack; only an unacked full register overruns.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_frame_err <= ferr;
            if (load) begin
                rx_data    <= shift;
                rx_valid   <= 1'b1;
                rx_overrun <= rx_valid && !rx_ack;
            end else begin
                rx_overrun <= 1'b0;
                if (rx_ack) begin
                    rx_valid <= 1'b0;
                end
            end
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at BAUD_DIV = 4: directed frames driven bit by bit, with
// a byte scoreboard popped by an independent output monitor.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         busy_cnt = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;
    int         rise_cyc = 0;
    int         frame_start = 0;
    logic [7:0] exp_q[$];

    uart_rx #(
        .BAUD_DIV(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rxd         (rxd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ack      (rx_ack),
        .rx_frame_err(rx_frame_err),
        .rx_overrun  (rx_overrun),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame (64 clocks per bit); limit truncates it mid-frame.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int limit);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        frame_start = cyc;
        for (int i = 0; i < limit && i < 640; i++) begin
            rxd = f[i/64];
            clk_wait(1);
        end
    endtask

    task automatic ack_byte();
        rx_ack = 1'b1;
        clk_wait(1);
        rx_ack = 1'b0;
    endtask

    // Output monitor: a new byte is a valid rise, an overrun, or a load
    // that coincided with the previous cycle's ack.
    initial begin
        logic prev_valid;
        logic prev_ack;
        prev_valid = 1'b0;
        prev_ack   = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_busy) busy_cnt++;
            if (rx_frame_err) ferr_cnt++;
            if (rx_overrun) ovr_cnt++;
            if (rx_valid && (!prev_valid || rx_overrun || prev_ack)) begin
                if (!prev_valid) rise_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: got byte %02h, expected none", rx_data);
                end else begin
                    chk("sb_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                end
            end
            prev_valid = rx_valid;
            prev_ack   = rx_ack;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0;
        int f0;
        int o0;

        // Reset state
        clk_wait(3);
        chk("rst_data", {24'd0, rx_data}, 32'h00);
        chk("rst_valid", {31'd0, rx_valid}, 0);
        chk("rst_ferr", {31'd0, rx_frame_err}, 0);
        chk("rst_ovr", {31'd0, rx_overrun}, 0);
        chk("rst_busy", {31'd0, rx_busy}, 0);
        reset = 1'b1;
        clk_wait(10);

        // 1: 0xA5, valid visible at cycle 611, held until ack
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 640);
        chk("t1_latency", rise_cyc - frame_start, 611);
        clk_wait(20);
        chk("t1_valid_held", {31'd0, rx_valid}, 1);
        chk("t1_data", {24'd0, rx_data}, 32'hA5);
        ack_byte();
        chk("t1_valid_clr", {31'd0, rx_valid}, 0);
        chk("t1_data_kept", {24'd0, rx_data}, 32'hA5);

        // 2: 16-clock glitch is a false start
        b0 = busy_cnt;
        f0 = ferr_cnt;
        rxd = 1'b0;
        clk_wait(16);
        rxd = 1'b1;
        clk_wait(18);
        chk("t2_busy_c34", {31'd0, rx_busy}, 1);
        clk_wait(1);
        chk("t2_idle_c35", {31'd0, rx_busy}, 0);
        chk("t2_busy_seen", {31'd0, busy_cnt > b0}, 1);
        chk("t2_no_valid", {31'd0, rx_valid}, 0);
        chk("t2_no_ferr", ferr_cnt - f0, 0);

        // 3: framing error, held-low line ignored, then recovery
        rxd = 1'b1;
        clk_wait(64);
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 640);
        chk("t3_ferr_pulses", ferr_cnt - f0, 1);
        chk("t3_no_valid", {31'd0, rx_valid}, 0);
        b0 = busy_cnt;
        clk_wait(200);
        chk("t3_no_restart", busy_cnt - b0, 0);
        rxd = 1'b1;
        clk_wait(64);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, 640);
        clk_wait(4);
        chk("t3_valid", {31'd0, rx_valid}, 1);
        chk("t3_data", {24'd0, rx_data}, 32'h7E);
        ack_byte();

        // 4a: back-to-back without ack overruns
        o0 = ovr_cnt;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1, 640);
        send_frame(8'h22, 1'b1, 640);
        clk_wait(4);
        chk("t4_ovr", ovr_cnt - o0, 1);
        chk("t4_data", {24'd0, rx_data}, 32'h22);
        chk("t4_valid", {31'd0, rx_valid}, 1);
        ack_byte();

        // 4b: ack in the load cycle is not an overrun
        o0 = ovr_cnt;
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        fork
            begin
                send_frame(8'h33, 1'b1, 640);
                send_frame(8'h44, 1'b1, 640);
            end
            begin
                clk_wait(1250);
                ack_byte();
            end
        join
        clk_wait(4);
        chk("t4b_no_ovr", ovr_cnt - o0, 0);
        chk("t4b_valid", {31'd0, rx_valid}, 1);
        chk("t4b_data", {24'd0, rx_data}, 32'h44);
        ack_byte();
        chk("t4b_valid_clr", {31'd0, rx_valid}, 0);

        // 5: reset mid-frame
        send_frame(8'h5A, 1'b1, 300);
        reset = 1'b0;
        #1;
        chk("t5_rst_data", {24'd0, rx_data}, 32'h00);
        chk("t5_rst_valid", {31'd0, rx_valid}, 0);
        chk("t5_rst_ferr", {31'd0, rx_frame_err}, 0);
        chk("t5_rst_ovr", {31'd0, rx_overrun}, 0);
        chk("t5_rst_busy", {31'd0, rx_busy}, 0);
        clk_wait(3);
        rxd = 1'b1;
        reset = 1'b1;
        clk_wait(8);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 640);
        clk_wait(4);
        chk("t5_valid", {31'd0, rx_valid}, 1);
        chk("t5_data", {24'd0, rx_data}, 32'h81);
        ack_byte();

        // 6: line low across reset release
        reset = 1'b0;
        rxd = 1'b0;
        clk_wait(2);
        reset = 1'b1;
        b0 = busy_cnt;
        clk_wait(100);
        chk("t6_no_busy", busy_cnt - b0, 0);
        chk("t6_no_valid", {31'd0, rx_valid}, 0);
        rxd = 1'b1;
        clk_wait(64);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, 640);
        clk_wait(4);
        chk("t6_valid", {31'd0, rx_valid}, 1);
        chk("t6_data", {24'd0, rx_data}, 32'hC3);
        ack_byte();

        clk_wait(4);
        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
